lif_neuron_mc: RTL and testbench

LIF_NEURON_MC -- requirements
Module: lif_neuron_mc

---
 rtl/snn_pkg.sv | 15 +
 rtl/lif_syn_accum.sv | 25 ++
 rtl/lif_neuron_mc.sv | 110 +++++++++++
 tb/tb_lif_neuron_mc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and defaults for the spiking neuron blocks.
// Holds the LIF state encoding and the default parameter values.
package snn_pkg;

  typedef enum logic {
    INTEGRATE = 1'b0,
    REFRACT   = 1'b1
  } lif_state_e;

  localparam int N_IN_DEF      = 4;
  localparam int W_WIDTH_DEF   = 8;
  localparam int V_WIDTH_DEF   = 16;
  localparam int REF_WIDTH_DEF = 4;

endpackage

// File: rtl/lif_syn_accum.sv
// Synaptic accumulator: signed sum of active weights.
// The output is wide enough that no spike pattern can overflow it.
module lif_syn_accum #(
  parameter int N_IN    = 4,
  parameter int W_WIDTH = 8,
  parameter int SUM_W   = 11
) (
  input  logic [N_IN-1:0]         input_spike,
  input  logic [N_IN*W_WIDTH-1:0] weight,
  output logic [SUM_W-1:0]        sum
);

  // Sign-extend each active weight and add it in.
  always_comb begin
    logic [W_WIDTH-1:0] wi;
    sum = '0;
    wi  = '0;
    for (int i = 0; i < N_IN; i++) begin
      wi = weight[i*W_WIDTH +: W_WIDTH];
      if (input_spike[i])
        sum = sum + {{(SUM_W-W_WIDTH){wi[W_WIDTH-1]}}, wi};
    end
  end

endmodule

// File: rtl/lif_neuron_mc.sv
// Leaky integrate-and-fire neuron with refractory period.
// Integrates on each step strobe, clamps, fires and optionally rests.
module lif_neuron_mc
  import snn_pkg::*;
#(
  parameter int N_IN      = N_IN_DEF,
  parameter int W_WIDTH   = W_WIDTH_DEF,
  parameter int V_WIDTH   = V_WIDTH_DEF,
  parameter int REF_WIDTH = REF_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    step_en,
  input  logic [N_IN-1:0]         input_spike,
  input  logic [N_IN*W_WIDTH-1:0] weight,
  input  logic [V_WIDTH-1:0]      threshold,
  input  logic [V_WIDTH-1:0]      leak_factor,
  input  logic [REF_WIDTH-1:0]    refractory_period,
  input  logic                    reset_mode,
  output logic                    output_spike,
  output logic [V_WIDTH-1:0]      membrane_v,
  output logic                    refractory
);

  localparam int SUM_W = W_WIDTH + $clog2(N_IN) + 1;
  localparam int VR_W  = V_WIDTH + 2;

  lif_state_e           state, state_n;
  logic [REF_WIDTH-1:0] cnt, cnt_n;
  logic [V_WIDTH-1:0]   mem_n;
  logic                 spike_n;
  logic [SUM_W-1:0]     sum;
  logic signed [VR_W-1:0] v_raw;
  logic [V_WIDTH-1:0]   v_next;
  logic                 fire;

  lif_syn_accum #(
    .N_IN    (N_IN),
    .W_WIDTH (W_WIDTH),
    .SUM_W   (SUM_W)
  ) u_accum (
    .input_spike (input_spike),
    .weight      (weight),
    .sum         (sum)
  );

  assign v_raw = $signed({2'b00, membrane_v})
               + $signed({{(VR_W-SUM_W){sum[SUM_W-1]}}, sum})
               - $signed({2'b00, leak_factor});

  // Saturate the raw potential into the unsigned membrane range.
  always_comb begin
    v_next = v_raw[V_WIDTH-1:0];
    if (v_raw[VR_W-1])
      v_next = '0;
    else if (v_raw[V_WIDTH])
      v_next = '1;
  end

  assign fire       = (v_next >= threshold);
  assign refractory = (state == REFRACT);

  // Next state, membrane, counter and pulse for this strobe.
  always_comb begin
    state_n = state;
    mem_n   = membrane_v;
    cnt_n   = cnt;
    spike_n = 1'b0;
    if (step_en) begin
      unique case (state)
        INTEGRATE: begin
          if (fire) begin
            spike_n = 1'b1;
            mem_n   = reset_mode ? (v_next - threshold) : '0;
            if (refractory_period != '0) begin
              cnt_n   = refractory_period;
              state_n = REFRACT;
            end
          end else begin
            mem_n = v_next;
          end
        end
        REFRACT: begin
          cnt_n = cnt - REF_WIDTH'(1);
          if (cnt <= REF_WIDTH'(1)) begin
            cnt_n   = '0;
            state_n = INTEGRATE;
          end
        end
        default: state_n = INTEGRATE;
      endcase
    end
  end

  // All neuron state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INTEGRATE;
      membrane_v   <= '0;
      cnt          <= '0;
      output_spike <= 1'b0;
    end else begin
      state        <= state_n;
      membrane_v   <= mem_n;
      cnt          <= cnt_n;
      output_spike <= spike_n;
    end
  end

endmodule

// File: tb/tb_lif_neuron_mc.sv
// Bench for lif_neuron_mc: directed cases plus random steps.
// Expected values come from an integer model of the neuron.
module tb_lif_neuron_mc;

  localparam int N_IN = 4;
  localparam int WW   = 8;
  localparam int VW   = 16;
  localparam int RW   = 4;
  localparam int VMAX = 65535;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          step_en;
  logic [N_IN-1:0]    spk;
  logic [N_IN*WW-1:0] weight;
  logic [VW-1:0] thr;
  logic [VW-1:0] leak;
  logic [RW-1:0] refp;
  logic          mode;
  logic          output_spike;
  logic [VW-1:0] membrane_v;
  logic          refractory;

  int w [N_IN];
  int m_mem;
  int m_refr;
  int m_spk;
  int n_chk;
  int n_pass;

  lif_neuron_mc #(
    .N_IN      (N_IN),
    .W_WIDTH   (WW),
    .V_WIDTH   (VW),
    .REF_WIDTH (RW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .step_en           (step_en),
    .input_spike       (spk),
    .weight            (weight),
    .threshold         (thr),
    .leak_factor       (leak),
    .refractory_period (refp),
    .reset_mode        (mode),
    .output_spike      (output_spike),
    .membrane_v        (membrane_v),
    .refractory        (refractory)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d);
    w[0] = a;
    w[1] = b;
    w[2] = c;
    w[3] = d;
    for (int i = 0; i < N_IN; i++)
      weight[i*WW +: WW] = WW'(w[i]);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mem"}, int'(membrane_v), m_mem);
    chk({tag, ".spk"}, int'(output_spike), m_spk);
    chk({tag, ".ref"}, int'(refractory), int'(m_refr > 0));
  endtask

  task automatic step(input bit en, input string tag);
    int sum;
    int vn;
    step_en = en;
    @(posedge clk);
    m_spk = 0;
    if (en) begin
      if (m_refr > 0) begin
        m_refr--;
      end else begin
        sum = 0;
        for (int i = 0; i < N_IN; i++)
          if (spk[i]) sum += w[i];
        vn = m_mem + sum - int'(leak);
        if (vn < 0) vn = 0;
        if (vn > VMAX) vn = VMAX;
        if (vn >= int'(thr)) begin
          m_spk  = 1;
          m_mem  = mode ? vn - int'(thr) : 0;
          m_refr = int'(refp);
        end else begin
          m_mem = vn;
        end
      end
    end
    #1;
    check_all(tag);
    step_en = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_mem  = 0;
    m_refr = 0;
    m_spk  = 0;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    step_en = 1'b0;
    spk     = '0;
    thr     = 16'd35;
    leak    = '0;
    refp    = '0;
    mode    = 1'b0;
    set_w(10, 10, 10, 10);
    m_mem  = 0;
    m_refr = 0;
    m_spk  = 0;
    #12;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // basic fire, reset-to-zero then subtract modes
    spk = 4'hF;
    step(1'b1, "fire_m0");
    chk("fire_m0.v", int'(membrane_v), 0);
    step(1'b0, "idle");
    mode = 1'b1;
    step(1'b1, "fire_m1");
    chk("fire_m1.v", int'(membrane_v), 5);
    step(1'b0, "idle2");

    // negative sum clamps at zero
    do_reset("rst2");
    thr  = 16'd1000;
    spk  = 4'h1;
    set_w(20, 0, 0, 0);
    step(1'b1, "build20");
    set_w(-50, 0, 0, 0);
    leak = 16'd5;
    step(1'b1, "clamp0");
    chk("clamp0.v", int'(membrane_v), 0);

    // saturation at full scale
    do_reset("rst3");
    leak = '0;
    thr  = 16'hFFFF;
    mode = 1'b0;
    spk  = 4'hF;
    set_w(127, 127, 127, 127);
    for (int i = 0; i < 128; i++) step(1'b1, "ramp");
    set_w(127, 127, 127, 125);
    step(1'b1, "ramp_end");
    chk("ramp.v", int'(membrane_v), 65530);
    set_w(20, 20, 20, 20);
    step(1'b1, "sat_fire");
    chk("sat_fire.s", int'(output_spike), 1);

    // refractory of 3, inputs still driven
    do_reset("rst4");
    thr  = 16'd35;
    refp = 4'd3;
    set_w(10, 10, 10, 10);
    step(1'b1, "rf_fire");
    refp = 4'd9;
    for (int i = 0; i < 3; i++) step(1'b1, "rf_hold");
    step(1'b1, "rf_resume");
    chk("rf_resume.s", int'(output_spike), 1);

    // back-to-back pulses without refractory
    do_reset("rst5");
    refp = '0;
    thr  = '0;
    for (int i = 0; i < 5; i++) step(1'b1, "b2b");

    // async reset while resting with membrane 100
    do_reset("rst6");
    mode = 1'b1;
    thr  = 16'd50;
    refp = 4'd3;
    set_w(100, 50, 0, 0);
    spk  = 4'h3;
    step(1'b1, "pre_rf");
    chk("pre_rf.v", int'(membrane_v), 100);
    step(1'b1, "in_rf");
    do_reset("rf_rst");
    step(1'b0, "post_rst");

    // randomized steps
    for (int k = 0; k < 400; k++) begin
      spk  = N_IN'($urandom);
      set_w(int'($urandom_range(140)) - 60, int'($urandom_range(140)) - 60,
            int'($urandom_range(140)) - 60, int'($urandom_range(140)) - 60);
      thr  = VW'($urandom_range(300));
      leak = VW'($urandom_range(20));
      refp = RW'($urandom_range(3));
      mode = 1'($urandom);
      step(1'($urandom_range(3) != 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
